board_input_debouncer: RTL and testbench



---
 rtl/board_input_debouncer.sv | 80 ++++++++
 tb/tb_board_input_debouncer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/board_input_debouncer.sv
// rtl/board_input_debouncer.sv - multi-channel synchroniser, debouncer and edge-pulse generator
// Optional per-channel press toggle enabled by BOARD_INPUT_DEBOUNCER_TOGGLE_EN.
module board_input_debouncer #(
  parameter int                   CHANNELS      = 4,
  parameter int                   STABLE_CYCLES = 500000,
  parameter logic [CHANNELS-1:0]  RESET_VALUE   = {CHANNELS{1'b0}}
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change,
  output logic [CHANNELS-1:0] toggled
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CW-1:0]       count [CHANNELS];
  logic [CHANNELS-1:0] expire;

  // A channel commits its new level on the edge its counter has seen it differ long enough.
  always_comb begin
    expire = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      expire[i] = (sync2[i] != debounced[i]) && (count[i] == LAST);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1      <= RESET_VALUE;
      sync2      <= RESET_VALUE;
      debounced  <= RESET_VALUE;
      rise_pulse <= '0;
      fall_pulse <= '0;
      any_change <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        count[i] <= '0;
      end
    end else begin
      sync1      <= raw_in;
      sync2      <= sync1;
      rise_pulse <= expire & sync2;
      fall_pulse <= expire & ~sync2;
      any_change <= |expire;
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync2[i] == debounced[i]) begin
          count[i] <= '0;
        end else if (expire[i]) begin
          debounced[i] <= sync2[i];
          count[i]     <= '0;
        end else begin
          count[i] <= count[i] + 1'b1;
        end
      end
    end
  end

`ifdef BOARD_INPUT_DEBOUNCER_TOGGLE_EN
  logic [CHANNELS-1:0] toggle_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_q ^ (expire & sync2);
    end
  end

  assign toggled = toggle_q;
`else
  assign toggled = {CHANNELS{1'b0}};
`endif

endmodule

// File: tb/tb_board_input_debouncer.sv
// tb/tb_board_input_debouncer.sv - table-driven scoreboard bench for board_input_debouncer
// Second instance covers an all-ones reset value with inputs held high.
module tb_board_input_debouncer;

  typedef struct {
    logic       rst_n;
    logic [3:0] raw;
    logic [3:0] deb;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
  } vec_t;

  typedef struct {
    int         row;
    logic [3:0] deb;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
    logic [3:0] tog;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic [3:0] raw_in;
  logic [3:0] debounced, rise_pulse, fall_pulse, toggled;
  logic       any_change;
  logic [3:0] raw_hi;
  logic [3:0] deb_hi, rise_hi, fall_hi, tog_hi;
  logic       any_hi;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks;
  int   failures;
  logic [3:0] exp_tog;

  board_input_debouncer #(.CHANNELS(4), .STABLE_CYCLES(4), .RESET_VALUE(4'b0000)) dut (
    .clock(clock), .reset_n(reset_n), .raw_in(raw_in), .debounced(debounced),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .any_change(any_change), .toggled(toggled)
  );

  board_input_debouncer #(.CHANNELS(4), .STABLE_CYCLES(4), .RESET_VALUE(4'b1111)) dut_hi (
    .clock(clock), .reset_n(reset_n), .raw_in(raw_hi), .debounced(deb_hi),
    .rise_pulse(rise_hi), .fall_pulse(fall_hi), .any_change(any_hi), .toggled(tog_hi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input logic rst_n, input logic [3:0] raw, input logic [3:0] deb,
                     input logic [3:0] rise, input logic [3:0] fall, input logic any);
    vec_t v;
    v.rst_n = rst_n; v.raw = raw; v.deb = deb; v.rise = rise; v.fall = fall; v.any = any;
    vecs.push_back(v);
  endtask

  // Input held from row 0; new level and pulse expected after the sixth edge.
  task automatic add_transition(input logic [3:0] raw, input logic [3:0] old);
    for (int j = 0; j < 7; j++) begin
      if (j < 5)       add(1'b1, raw, old, 4'b0, 4'b0, 1'b0);
      else if (j == 5) add(1'b1, raw, raw, raw & ~old, old & ~raw, |(raw ^ old));
      else             add(1'b1, raw, raw, 4'b0, 4'b0, 1'b0);
    end
  endtask

  task automatic chk(input string name, input int row, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%b expected=%b", name, row, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    checks   = 0;
    failures = 0;
    exp_tog  = 4'b0;
    reset_n  = 1'b0;
    raw_in   = 4'b0;
    raw_hi   = 4'b1111;

    for (int j = 0; j < 3; j++) add(1'b0, 4'b0101, 4'b0, 4'b0, 4'b0, 1'b0);
    for (int j = 0; j < 4; j++) add(1'b1, 4'b0000, 4'b0, 4'b0, 4'b0, 1'b0);
    add_transition(4'b0001, 4'b0000);
    for (int j = 0; j < 3; j++) add(1'b1, 4'b0011, 4'b0001, 4'b0, 4'b0, 1'b0);
    add(1'b1, 4'b0001, 4'b0001, 4'b0, 4'b0, 1'b0);
    for (int j = 0; j < 3; j++) add(1'b1, 4'b0011, 4'b0001, 4'b0, 4'b0, 1'b0);
    for (int j = 0; j < 6; j++) add(1'b1, 4'b0001, 4'b0001, 4'b0, 4'b0, 1'b0);
    add_transition(4'b1101, 4'b0001);
    add_transition(4'b0001, 4'b1101);
    add_transition(4'b0000, 4'b0001);
    add_transition(4'b0001, 4'b0000);
    add_transition(4'b0000, 4'b0001);
    add_transition(4'b0001, 4'b0000);
    add_transition(4'b0000, 4'b0001);
    // Reset after the counter has reached 2, then a full restart of the same press.
    for (int j = 0; j < 4; j++) add(1'b1, 4'b0001, 4'b0000, 4'b0, 4'b0, 1'b0);
    add(1'b0, 4'b0001, 4'b0000, 4'b0, 4'b0, 1'b0);
    add_transition(4'b0001, 4'b0000);

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clock);
      reset_n = vecs[r].rst_n;
      raw_in  = vecs[r].raw;
`ifdef BOARD_INPUT_DEBOUNCER_TOGGLE_EN
      if (!vecs[r].rst_n) exp_tog = 4'b0;
      else                exp_tog = exp_tog ^ vecs[r].rise;
`endif
      e.row = r; e.deb = vecs[r].deb; e.rise = vecs[r].rise; e.fall = vecs[r].fall;
      e.any = vecs[r].any; e.tog = exp_tog;
      sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty row=%0d actual=0 expected=1", r);
      end else begin
        e = sb.pop_front();
        chk("debounced", e.row, debounced, e.deb);
        chk("rise_pulse", e.row, rise_pulse, e.rise);
        chk("fall_pulse", e.row, fall_pulse, e.fall);
        chk("any_change", e.row, {3'b0, any_change}, {3'b0, e.any});
        chk("toggled", e.row, toggled, e.tog);
        chk("hi_debounced", e.row, deb_hi, 4'b1111);
        chk("hi_pulses", e.row, rise_hi | fall_hi | tog_hi, 4'b0000);
        chk("hi_any_change", e.row, {3'b0, any_hi}, 4'b0000);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
